// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin share of the async FIFO write port between N_REQ requesters (w_clk domain).
// Latency: 0 cycles req->gnt/winc/w_data (combinational); owner, FSM state and burst count registered.
// Backpressure: full=1 blocks every grant and freezes all state. Optional burst lock via `ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                          full,
  output logic [N_REQ-1:0]              gnt,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(N_REQ)-1:0]      owner
);

  localparam int IW = $clog2(N_REQ);

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("fifo_wr_arbiter: N_REQ must be within 2..16");
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_wr_arbiter: BURST_LEN must be at least 1");
  end

  // Round-robin pick: nearest requesting index after 'last', wrapping; MSB flags a hit.
  // Scanning from the farthest candidate to the nearest lets the nearest overwrite the result.
  function automatic logic [IW:0] rr_pick(input logic [IW-1:0] last, input logic [N_REQ-1:0] r);
    logic [IW:0] res;
    int          cand;
    res = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = (int'(last) + i) % N_REQ;
      if (r[cand]) res = {1'b1, cand[IW-1:0]};
    end
    return res;
  endfunction

  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  logic [IW:0]   rr_res;

`ifdef ARB_BURST_EN
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;
  localparam int CW = $clog2(BURST_LEN + 1);

  state_t        state;
  logic [CW-1:0] burst_cnt;
`endif

  // Candidate selection: round-robin when idle, the locked owner only while a burst is held.
  always_comb begin
    rr_res  = rr_pick(owner, req);
    sel_vld = rr_res[IW];
    sel_idx = rr_res[IW-1:0];
`ifdef ARB_BURST_EN
    if (state == LOCK) begin
      sel_vld = req[owner];
      sel_idx = owner;
    end
`endif
  end

  // Grant and write path; suppressed while full or while reset is asserted.
  always_comb begin
    gnt    = '0;
    winc   = 1'b0;
    w_data = '0;
    if (sel_vld && !full && w_rst) begin
      gnt[sel_idx] = 1'b1;
      winc         = 1'b1;
      w_data       = req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Owner tracks the last winner; reset value makes requester 0 the first priority.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      owner <= IW'(N_REQ - 1);
    end else if (winc) begin
      owner <= sel_idx;
    end
  end

`ifdef ARB_BURST_EN
  // Burst FSM: lock onto a winner for up to BURST_LEN words; frozen while full.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if (!full) begin
      case (state)
        IDLE: begin
          if (winc && (BURST_LEN > 1)) begin
            state     <= LOCK;
            burst_cnt <= CW'(1);
          end
        end
        LOCK: begin
          if (winc) begin
            if (burst_cnt + 1'b1 == CW'(BURST_LEN)) begin
              state     <= IDLE;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else begin
            // Owner let go mid-burst: this cycle is dead, re-arbitrate next cycle.
            state     <= IDLE;
            burst_cnt <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand-written burst sequences and
// randomized traffic against a rule-level reference model. Builds with or without ARB_BURST_EN.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
`ifdef ARB_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic            w_clk;
  logic            w_rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            full;
  logic [N-1:0]    gnt;
  logic            winc;
  logic [DW-1:0]   w_data;
  logic [1:0]      owner;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .winc     (winc),
    .w_data   (w_data),
    .owner    (owner)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       fl;
    logic [3:0] eg;
    logic [1:0] eo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice_of(input logic [N-1:0] onehot);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) if (onehot[i]) d = req_data[i*DW +: DW];
    return d;
  endfunction

  // Apply one cycle of inputs, check combinational outputs and owner mid-cycle, then advance.
  task automatic row(input string tag, input logic r, input logic [3:0] rq, input logic fl,
                     input logic [3:0] eg, input logic [1:0] eo);
    w_rst = r; req = rq; full = fl;
    #4;
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_winc"}, winc, |eg);
    chk({tag, "_wdata"}, w_data, slice_of(eg));
    chk({tag, "_owner"}, owner, eo);
    @(posedge w_clk); #1;
  endtask

  // Reference model state: last winner, burst lock flag, words taken in current burst.
  int m_owner;
  bit m_lock;
  int m_cnt;

  task automatic model_reset();
    m_owner = N - 1;
    m_lock  = 1'b0;
    m_cnt   = 0;
  endtask

  function automatic int model_winner();
    int w;
    w = -1;
    if (w_rst && !full) begin
      if (m_lock) begin
        if (req[m_owner]) w = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req[(m_owner + k) % N]) w = (m_owner + k) % N;
        end
      end
    end
    return w;
  endfunction

  task automatic model_edge(input int w);
    if (w_rst && !full) begin
      if (m_lock) begin
        if (w >= 0) begin
          m_cnt++;
          if (m_cnt == BL) begin m_lock = 1'b0; m_cnt = 0; end
        end else begin
          m_lock = 1'b0; m_cnt = 0;
        end
      end else if (w >= 0 && BURST_ON && BL > 1) begin
        m_lock = 1'b1; m_cnt = 1;
      end
      if (w >= 0) m_owner = w;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    int            w;

    w_rst = 1'b0; req = '0; full = 1'b0; req_data = 32'hD3C2B1A0;
    repeat (2) @(posedge w_clk);
    #1;

`ifndef ARB_BURST_EN
    // Directed table: reset, fairness, full stall, sparse/wrap, full with request, mid reset.
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd3});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd3});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd0});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd1});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd2});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd3});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd0});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd1});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd2});
    tbl.push_back('{1'b1, 4'b0110, 1'b0, 4'b0010, 2'd3});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 4'b0110, 1'b0, 4'b0100, 2'd1});
    tbl.push_back('{1'b1, 4'b0011, 1'b0, 4'b0001, 2'd2});
    tbl.push_back('{1'b1, 4'b0011, 1'b0, 4'b0010, 2'd0});
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 4'b1000, 1'b1, 4'b0000, 2'd1});
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 4'b1000, 2'd1});
    tbl.push_back('{1'b1, 4'b0010, 1'b0, 4'b0010, 2'd3});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 4'b0000, 2'd3});
    tbl.push_back('{1'b1, 4'b0011, 1'b0, 4'b0001, 2'd3});
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0});
    for (int i = 0; i < tbl.size(); i++)
      row($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rq, tbl[i].fl, tbl[i].eg, tbl[i].eo);

    // Single requester streams at one word per cycle.
    row("thru0", 1'b1, 4'b0100, 1'b0, 4'b0100, 2'd0);
    row("thru1", 1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2);
    row("thru2", 1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2);
`else
    // Full bursts: four words to req0, then four to req1, then back to req0.
    row("b_rst", 1'b0, 4'b0011, 1'b0, 4'b0000, 2'd3);
    row("b_a0",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd3);
    row("b_a1",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    row("b_a2",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    row("b_a3",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    row("b_b0",  1'b1, 4'b0011, 1'b0, 4'b0010, 2'd0);
    row("b_b1",  1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1);
    row("b_b2",  1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1);
    row("b_b3",  1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1);
    row("b_c0",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd1);
    // Owner drops after two words: one dead cycle, then req1.
    row("d_rst", 1'b0, 4'b0011, 1'b0, 4'b0000, 2'd3);
    row("d_a0",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd3);
    row("d_a1",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    row("d_dead",1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0);
    row("d_b0",  1'b1, 4'b0010, 1'b0, 4'b0010, 2'd0);
    // Full during a lock freezes count: 1 + full + 3 more words = 4 in the burst.
    row("f_rst", 1'b0, 4'b0011, 1'b0, 4'b0000, 2'd3);
    row("f_a0",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd3);
    row("f_full",1'b1, 4'b0011, 1'b1, 4'b0000, 2'd0);
    row("f_a1",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    row("f_a2",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    row("f_a3",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    row("f_b0",  1'b1, 4'b0011, 1'b0, 4'b0010, 2'd0);
    // Reset mid-burst of req1 abandons the burst; req0 wins afterwards.
    row("m_rst", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd3);
    row("m_b0",  1'b1, 4'b0010, 1'b0, 4'b0010, 2'd3);
    row("m_b1",  1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1);
    row("m_mid", 1'b0, 4'b0010, 1'b0, 4'b0000, 2'd3);
    row("m_a0",  1'b1, 4'b0011, 1'b0, 4'b0001, 2'd3);
`endif

    // Randomized traffic against the reference model.
    w_rst = 1'b0; req = '0; full = 1'b0;
    @(posedge w_clk); #1;
    model_reset();
    w_rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) != 0) req = req; else req = N'($urandom_range(0, 15));
      req_data = $urandom();
      full     = ($urandom_range(0, 4) == 0);
      w_rst    = ($urandom_range(0, 99) != 0);
      if (!w_rst) model_reset();
      w  = model_winner();
      eg = '0;
      ed = '0;
      if (w >= 0) begin
        eg[w] = 1'b1;
        ed    = req_data[w*DW +: DW];
      end
      #4;
      chk("rnd_gnt", gnt, eg);
      chk("rnd_winc", winc, (w >= 0));
      chk("rnd_wdata", w_data, ed);
      chk("rnd_owner", owner, m_owner);
      @(posedge w_clk);
      model_edge(w);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO's write-clock domain between `N_REQ` requesters. It sits entirely in the `w_clk` domain, directly in front of the FIFO write-pointer logic. Each cycle it picks at most one requester, drives `winc` and the write data, and acknowledges the winner. It never issues a write while `full` is high, so no accepted word is ever dropped.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: FIFO word width.
- `BURST_LEN`, default 4: maximum words per locked burst, used only when `ARB_BURST_EN` is defined; minimum 1.
- `w_clk`  input  1: write-domain clock, rising edge.
- `w_rst`  input  1: asynchronous, active-low reset.
- `req`  input  `N_REQ`: per-requester write request; level, held until acknowledged.
- `req_data`  input  `N_REQ*DATA_WIDTH`: flattened request data; slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `full`  input  1: FIFO full flag from the write-side pointer logic.
- `gnt`  output  `N_REQ`: one-hot acknowledge. `gnt[i]` high means requester i's word is written this cycle.
- `winc`  output  1: write enable to the FIFO, equal to `|gnt`.
- `w_data`  output  `DATA_WIDTH`: `req_data` slice of the granted requester; 0 when no grant.
- `owner`  output  `$clog2(N_REQ)`: registered index of the last granted requester.

## Operation
- `gnt`, `winc` and `w_data` are combinational from `req`, `full` and the registered state. `owner`, the FSM state and the burst counter are registered.
- `full` = 1 forces `gnt` = 0 and `winc` = 0. All state holds while `full` is high.
- Round-robin search starts at `(owner+1) mod N_REQ` and wraps. The first index with `req` high wins.
- On every cycle with `winc` = 1, `owner` takes the winner's index on the next edge. Otherwise `owner` holds.
- Only one `gnt` bit is ever high. `gnt` never asserts for a requester whose `req` is low.
- A requester keeps `req` and its data stable until it sees `gnt`. It may drop or renew `req` in the cycle after `gnt`.
- Wrap-around: with `owner` = `N_REQ-1`, the search starts at index 0.

## Timing
- Reset (`w_rst` low, asynchronous): `owner` = `N_REQ-1`, so requester 0 has top priority. State = IDLE and burst count = 0. With `req` = 0, `gnt` = 0, `winc` = 0 and `w_data` = 0.
- Latency from `req` to `gnt` is 0 cycles when the requester wins and `full` = 0.
- Throughput is one word per cycle. A single requester holding `req` high is granted every cycle while `full` = 0.
- `full` rising in the same cycle as a `req`: no grant that cycle. The request waits and keeps its priority position.
- Reset mid-operation clears the state immediately. An in-progress burst is abandoned, and no write occurs while `w_rst` is low.

## Configuration
- `ARB_BURST_EN` defined: a two-state FSM, IDLE and LOCK, is compiled in, together with a burst counter of `$clog2(BURST_LEN+1)` bits.
  - In IDLE, round-robin selection applies. An accepted word moves the FSM to LOCK with count = 1, unless `BURST_LEN` = 1, in which case it stays in IDLE.
  - In LOCK, only `req[owner]` can be granted. Each accepted word increments the count.
  - LOCK returns to IDLE on the edge after the accept that makes count = `BURST_LEN`.
  - LOCK also returns to IDLE on any edge where `req[owner]` is low. That cycle grants nothing (one dead cycle).
  - `full` in LOCK holds both the state and the count.
  - Count clears on entry to IDLE.
- `ARB_BURST_EN` undefined: no FSM or counter exists, and every accepted word re-arbitrates.

## Test plan
- Reset: drive `w_rst` low with `req` = 4'b1111. Required: `gnt` = 0, `winc` = 0, `w_data` = 0, `owner` = 3. After release, the first grant goes to req0.
- Fairness, burst mode off: hold `req` = 4'b1111 with `full` = 0 for 8 cycles. Required: `gnt` sequence 0,1,2,3,0,1,2,3 and `w_data` equal to each winner's slice.
- Full stall: hold `req` = 4'b0110 and raise `full` for 3 cycles after req1 is granted. Required: `winc` = 0 and `owner` = 1 during the stall. req2 is granted on the first cycle `full` is low.
- Sparse and wrap: `owner` = 2, `req` = 4'b0011. Required: req0 granted, then req1, then `winc` = 0 once `req` clears.
- Burst, `ARB_BURST_EN` with `BURST_LEN` = 4: hold `req` = 4'b0011. Required: four consecutive grants to req0, then four to req1. If req0 drops `req` after 2 words, expect 1 dead cycle and then req1 granted.
- Reset mid-burst: assert `w_rst` after 2 words of a req1 burst. Required: `winc` = 0 immediately. After release, state = IDLE, `owner` = 3, and req0 wins if requesting.
